// File: rtl/sigma_delta_adc.sv
// sigma_delta_adc: first-order sigma-delta ADC front end using an external
// comparator and RC integrator. The comparator output is synchronized and
// fed straight back as the 1-bit DAC. The same bit stream is decimated by
// counting ones over a free-running 2^DECIM_LOG2-cycle window.
//
// Ports:
//   Clk         system clock, rising edge
//   Reset       asynchronous, active-high reset
//   CompIn      comparator result (asynchronous to Clk)
//   FbOut       1-bit feedback to the RC integrator
//   Sample      decimated excess-128 sample (8'h80 = midscale)
//   SampleValid one-cycle strobe, high in the cycle Sample is updated
//   EarOut      hysteresis-thresholded level derived from Sample
module sigma_delta_adc #(
  parameter int unsigned DECIM_LOG2 = 8,
  parameter logic [7:0]  HYST_HI    = 8'd160,
  parameter logic [7:0]  HYST_LO    = 8'd96
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       CompIn,
  output logic       FbOut,
  output logic [7:0] Sample,
  output logic       SampleValid,
  output logic       EarOut
);

  localparam int unsigned AW = DECIM_LOG2 + 1;

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_FbOut;
  logic [DECIM_LOG2-1:0] r_WinCnt;
  logic [AW-1:0]         r_Acc;
  logic [7:0]            r_Sample;
  logic                  r_SampleValid;
  logic                  r_EarOut;

  logic                  w_win_end;
  logic [AW-1:0]         w_total;
  logic [7:0]            w_sample_next;

  // The window's last bit is still in sync2 on the closing edge, so it is
  // added here rather than waiting for it to reach the accumulator.
  assign w_win_end = &r_WinCnt;
  assign w_total   = r_Acc + AW'(r_sync2);

  // A full window of ones (Total = 2^DECIM_LOG2) does not fit the slice.
  always_comb begin
    w_sample_next = w_total[DECIM_LOG2-1 -: 8];
    if (w_total[DECIM_LOG2]) begin
      w_sample_next = '1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_FbOut <= 1'b0;
    end else begin
      r_sync1 <= CompIn;
      r_sync2 <= r_sync1;
      r_FbOut <= r_sync2;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_WinCnt      <= '0;
      r_Acc         <= '0;
      r_Sample      <= 8'h80;
      r_SampleValid <= 1'b0;
    end else begin
      r_WinCnt      <= r_WinCnt + 1'b1;
      r_SampleValid <= 1'b0;
      if (w_win_end) begin
        r_Acc         <= '0;
        r_Sample      <= w_sample_next;
        r_SampleValid <= 1'b1;
      end else begin
        r_Acc <= w_total;
      end
    end
  end

  // Evaluated one edge after the Sample update so the new Sample is used.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_EarOut <= 1'b0;
    end else if (r_SampleValid) begin
      if (r_Sample >= HYST_HI) begin
        r_EarOut <= 1'b1;
      end else if (r_Sample <= HYST_LO) begin
        r_EarOut <= 1'b0;
      end
    end
  end

  assign FbOut       = r_FbOut;
  assign Sample      = r_Sample;
  assign SampleValid = r_SampleValid;
  assign EarOut      = r_EarOut;

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Testbench for sigma_delta_adc (DECIM_LOG2 = 8, default thresholds).
// Stimulus is described per window: either a count of ones placed at the
// end of the window, or an alternating pattern. Windows are aligned to the
// accumulator, i.e. window w sums CompIn driven for edges 256w-1..256w+254.
module tb_sigma_delta_adc;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       CompIn = 1'b0;
  logic       FbOut;
  logic [7:0] Sample;
  logic       SampleValid;
  logic       EarOut;

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  typedef struct {
    logic [7:0] s;
    logic       ear;
    int         at_edge;
  } exp_t;
  exp_t q[$];

  int ones[8];
  bit tog[8];

  sigma_delta_adc #(.DECIM_LOG2(8), .HYST_HI(8'd160), .HYST_LO(8'd96)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .CompIn(CompIn),
    .FbOut(FbOut),
    .Sample(Sample),
    .SampleValid(SampleValid),
    .EarOut(EarOut)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp_v, edge_n);
    end
  endtask

  function automatic logic cval(input int e);
    int w;
    int slot;
    w = (e + 1) / 256;
    slot = (e + 1) % 256;
    if (w > 7) return 1'b0;
    if (tog[w]) return logic'(slot % 2);
    return logic'(slot >= 256 - ones[w]);
  endfunction

  task automatic clear_tab();
    for (int i = 0; i < 8; i++) begin
      ones[i] = 0;
      tog[i] = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] s, input logic ear, input int at_edge);
    exp_t x;
    x.s = s;
    x.ear = ear;
    x.at_edge = at_edge;
    q.push_back(x);
  endtask

  // Called at a negedge; asserts Reset mid-phase, checks the asynchronous
  // reset values, then releases at a negedge so edge 1 is the next posedge.
  task automatic do_reset(input string tag);
    #2 Reset = 1'b1;
    #1;
    chk({tag, "_rst_fbout"}, int'(FbOut), 0);
    chk({tag, "_rst_sample"}, int'(Sample), 'h80);
    chk({tag, "_rst_valid"}, int'(SampleValid), 0);
    chk({tag, "_rst_ear"}, int'(EarOut), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    edge_n = 0;
  endtask

  task automatic run_edges(input int from, input int to);
    for (int e = from; e <= to; e++) begin
      CompIn = cval(e);
      @(posedge Clk);
      edge_n = e;
      @(negedge Clk);
    end
  endtask

  task automatic chk_drained(input string name);
    chk(name, q.size(), 0);
    q.delete();
  endtask

  // Monitor: pops one expectation per SampleValid, then checks EarOut and
  // that the strobe dropped on the following cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge Clk);
      if (SampleValid === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got SampleValid=1 expected 0 (edge %0d)", edge_n);
        end else begin
          x = q.pop_front();
          chk("sample", int'(Sample), int'(x.s));
          chk("valid_edge", edge_n, x.at_edge);
          @(negedge Clk);
          chk("ear", int'(EarOut), int'(x.ear));
          chk("valid_width", int'(SampleValid), 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge Clk);

    // Constant 0: every window 00, EarOut and FbOut stay low.
    clear_tab();
    do_reset("zero");
    push(8'h00, 1'b0, 256);
    push(8'h00, 1'b0, 512);
    run_edges(1, 2 * 256 + 2);
    chk("zero_fbout", int'(FbOut), 0);
    chk_drained("zero_pending");

    // Constant 1 then toggling: FE (flush eats two), saturated FF, then
    // midscale while EarOut holds high.
    clear_tab();
    ones[0] = 256; ones[1] = 256; tog[2] = 1'b1; tog[3] = 1'b1;
    do_reset("ones");
    push(8'hFE, 1'b1, 256);
    push(8'hFF, 1'b1, 512);
    push(8'h80, 1'b1, 768);
    push(8'h80, 1'b1, 1024);
    run_edges(1, 2);
    chk("fbout_edge2", int'(FbOut), 0);
    run_edges(3, 3);
    chk("fbout_edge3", int'(FbOut), 1);
    run_edges(4, 4 * 256 + 2);
    chk_drained("ones_pending");

    // Hysteresis: 170 sets, 120 holds, 90 clears.
    clear_tab();
    ones[0] = 170; ones[1] = 120; ones[2] = 90;
    do_reset("hyst");
    push(8'hAA, 1'b1, 256);
    push(8'h78, 1'b1, 512);
    push(8'h5A, 1'b0, 768);
    run_edges(1, 3 * 256 + 2);
    chk_drained("hyst_pending");

    // Reset at WinCnt=100 of the second window discards it; restart gives FE.
    clear_tab();
    for (int i = 0; i < 8; i++) ones[i] = 256;
    do_reset("mid");
    push(8'hFE, 1'b1, 256);
    run_edges(1, 256 + 100);
    chk_drained("mid_pending");
    do_reset("mid2");
    push(8'hFE, 1'b1, 256);
    run_edges(1, 256 + 2);
    chk_drained("mid2_pending");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sigma_delta_adc.md
SIGMA_DELTA_ADC -- requirements
Module: sigma_delta_adc

Interface
REQ-001 The block SHALL provide parameter DECIM_LOG2, default 8: log2 of the decimation window length in Clk cycles; legal range 8..12.
REQ-002 The block SHALL provide parameter HYST_HI, default 8'd160: the Sample level at or above which EarOut sets.
REQ-003 The block SHALL provide parameter HYST_LO, default 8'd96: the Sample level at or below which EarOut clears; HYST_LO < HYST_HI.
REQ-004 Clk  input  1  system clock; all state changes on the rising edge.
REQ-005 Reset  input  1  reset, asynchronous, active-high.
REQ-006 CompIn  input  1  external comparator result, asynchronous to Clk; 1 = analog input above the RC integrator voltage.
REQ-007 FbOut  output  1  1-bit feedback to the external RC integrator; 1 drives the integrator up.
REQ-008 Sample  output  8  decimated unsigned sample in excess-128 format; 8'h80 = midscale.
REQ-009 SampleValid  output  1  one-Clk strobe that is high in the cycle Sample is updated.
REQ-010 EarOut  output  1  hysteresis-thresholded digital level for the tape/EAR path.

Function
REQ-011 CompIn SHALL pass through a two-flop synchronizer (sync1, sync2) before any use.
REQ-012 FbOut SHALL be a register loaded with sync2 every Clk; FbOut therefore lags CompIn by 3 edges.
REQ-013 The window counter WinCnt (DECIM_LOG2 bits) SHALL increment every Clk and wrap from all-ones to 0.
REQ-014 The ones accumulator Acc (DECIM_LOG2+1 bits) SHALL add the current sync2 value every Clk.
REQ-015 On the edge where WinCnt is all-ones, the block SHALL compute Total = Acc + sync2 (range 0..2^DECIM_LOG2) and clear Acc to 0 on that same edge, so the next window starts empty.
REQ-016 On that edge, Sample SHALL load Total[DECIM_LOG2-1 : DECIM_LOG2-8].
REQ-017 If Total equals 2^DECIM_LOG2, Sample SHALL instead saturate to 8'hFF.
REQ-018 SampleValid SHALL be high for exactly the one cycle following that edge and low otherwise.
REQ-019 Sample SHALL hold its value between updates.
REQ-020 EarOut SHALL be evaluated on the edge after the Sample update, using the new Sample: if Sample >= HYST_HI, set to 1; else if Sample <= HYST_LO, clear to 0; else hold.
REQ-021 No input other than Reset SHALL stall or restart a window; windows are free-running and back-to-back with no gap cycles.
REQ-022 The first window after reset SHALL include the two synchronizer-flush cycles, which count as 0.

Reset
REQ-023 While Reset is high, the following SHALL be forced immediately and asynchronously: sync1=0, sync2=0, FbOut=0, WinCnt=0, Acc=0, Sample=8'h80, SampleValid=0, EarOut=0.
REQ-024 A Reset asserted mid-window SHALL discard the partial window; no SampleValid is emitted for it.
REQ-025 After Reset deasserts, the first SampleValid SHALL occur exactly 2^DECIM_LOG2 edges later.
REQ-026 Reset release SHALL be synchronized externally; the block does not re-synchronize Reset deassertion.

Verification (DECIM_LOG2=8, default thresholds)
REQ-027 CompIn held 0 from reset -> FbOut stays 0; SampleValid at edge 256; Sample=8'h00 every window; EarOut stays 0.
REQ-028 CompIn held 1 from reset -> FbOut=1 from edge 3; first Sample=8'hFE (254 ones); second and later Sample=8'hFF (256 saturated); EarOut=1 one edge after the first SampleValid.
REQ-029 CompIn toggling every Clk -> Sample=8'h80 every window after the first; EarOut unchanged from its prior value.
REQ-030 Successive windows containing 170, 120 and 90 ones -> EarOut=1, then held at 1, then 0; each change occurs one edge after its SampleValid.
REQ-031 Reset pulsed at WinCnt=100 while CompIn=1 -> all outputs return to reset values at once, Sample=8'h80; next SampleValid 256 edges after release with Sample=8'hFE.
REQ-032 The bench SHALL check that SampleValid is never high on two consecutive cycles.
